// File: rtl/truth_pkg.sv
// Shared types and sizing for the truth-table sweeper.
package truth_pkg;

   localparam int DEF_N_VARS = 4;
   localparam int ROWS       = 2 ** DEF_N_VARS;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      SCAN  = 3'd2,
      EMIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Row/pointer counters carry one extra bit so "one past the last row" is representable.
   function automatic int cnt_w(input int n_vars);
      return n_vars + 1;
   endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Maxterm index stream.
// Handshake: the master raises mt_valid with mt_index/mt_last and holds all three stable
// until a rising edge where mt_valid & mt_ready are both high; that edge transfers the index.
// mt_valid never drops without such a transfer. mt_ready may change freely.
interface truth_table_sweeper_if #(
   parameter int N_VARS = 4
);
   logic              mt_valid;
   logic              mt_ready;
   logic [N_VARS-1:0] mt_index;
   logic              mt_last;

   modport master (output mt_valid, output mt_index, output mt_last, input mt_ready);
   modport slave  (input mt_valid, input mt_index, input mt_last, output mt_ready);
endinterface

// File: rtl/truth_table_sweeper_zero_scanner.sv
// Walks the captured truth mask looking for zero rows and owns the emitted-index registers.
module zero_scanner
   import truth_pkg::*;
#(
   parameter int N_VARS = DEF_N_VARS
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      step,
   input  logic                      load,
   input  logic                      advance,
   input  logic [2**N_VARS-1:0]      truth,
   input  logic [cnt_w(N_VARS)-1:0]  n_max,
   output logic                      found,
   output logic                      exhausted,
   output logic [N_VARS-1:0]         mt_index,
   output logic                      mt_last
);

   localparam int CW     = cnt_w(N_VARS);
   localparam int ROWS_L = 2 ** N_VARS;

   logic [CW-1:0] ptr;
   logic [CW-1:0] emit_cnt;

   assign exhausted = (ptr == CW'(ROWS_L));
   assign found     = !exhausted && !truth[ptr[N_VARS-1:0]];

   // Pointer walk, index capture and emitted-index count for the last flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         emit_cnt <= '0;
         mt_index <= '0;
         mt_last  <= 1'b0;
      end else if (clear) begin
         ptr      <= '0;
         emit_cnt <= '0;
      end else begin
         if (step) begin
            ptr <= ptr + CW'(1);
         end
         if (load) begin
            mt_index <= ptr[N_VARS-1:0];
            mt_last  <= ((emit_cnt + CW'(1)) == n_max);
            emit_cnt <= emit_cnt + CW'(1);
         end
         if (advance) begin
            ptr <= {1'b0, mt_index} + CW'(1);
         end
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input combination onto an external function, captures its truth mask,
// counts the zero rows and streams their indices out.
module truth_table_sweeper
   import truth_pkg::*;
#(
   parameter int N_VARS = DEF_N_VARS,
   parameter int SETTLE = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [N_VARS-1:0]         abcd,
   input  logic                      s_in,
   output logic [2**N_VARS-1:0]      truth,
   output logic [cnt_w(N_VARS)-1:0]  n_max,
   truth_table_sweeper_if.master     mt,
   output state_t                    dbg_state
);

   localparam int CW     = cnt_w(N_VARS);
   localparam int ROWS_L = 2 ** N_VARS;
   localparam int SW     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   state_t        state, state_nxt;
   logic [CW-1:0] idx;
   logic [SW-1:0] settle_cnt;
   logic          sample;
   logic          last_row;
   logic          found, exhausted;
   logic          sc_clear, sc_step, sc_load, sc_advance;
   logic          no_max;

   assign sample    = (state == DRIVE) && (settle_cnt == SW'(SETTLE));
   assign last_row  = (idx == CW'(ROWS_L - 1));
   assign no_max    = (n_max == '0);

   assign sc_clear   = (state == IDLE) && start;
   assign sc_step    = (state == SCAN) && !no_max && !found && !exhausted;
   assign sc_load    = (state == SCAN) && !no_max && found;
   assign sc_advance = (state == EMIT) && mt.mt_ready && !mt.mt_last;

   assign abcd        = (state == DRIVE) ? idx[N_VARS-1:0] : '0;
   assign done        = (state == DONE);
   assign mt.mt_valid = (state == EMIT);
   assign dbg_state   = state;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = DRIVE;
         DRIVE: if (sample && last_row) state_nxt = SCAN;
         SCAN: begin
            if (no_max || exhausted) state_nxt = DONE;
            else if (found)          state_nxt = EMIT;
         end
         EMIT: begin
            if (mt.mt_ready) state_nxt = mt.mt_last ? DONE : SCAN;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Sweep counters, truth capture, zero count and busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         settle_cnt <= '0;
         truth      <= '0;
         n_max      <= '0;
         busy       <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            truth      <= '0;
            n_max      <= '0;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b1;
         end else if (state == DRIVE) begin
            if (sample) begin
               truth[idx[N_VARS-1:0]] <= s_in;
               // Only a definite 0 counts; an X/Z sample is kept in the mask but not counted.
               if (s_in == 1'b0) n_max <= n_max + CW'(1);
               settle_cnt <= '0;
               if (!last_row) idx <= idx + CW'(1);
            end else begin
               settle_cnt <= settle_cnt + SW'(1);
            end
         end else if (state == DONE) begin
            busy <= 1'b0;
         end
      end
   end

   zero_scanner #(.N_VARS(N_VARS)) u_scanner (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (sc_clear),
      .step      (sc_step),
      .load      (sc_load),
      .advance   (sc_advance),
      .truth     (truth),
      .n_max     (n_max),
      .found     (found),
      .exhausted (exhausted),
      .mt_index  (mt.mt_index),
      .mt_last   (mt.mt_last)
   );

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=1 and SETTLE=3), one active at a time.
module tb_truth_table_sweeper;
   import truth_pkg::*;

   localparam int R = 16;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sel;
   logic        mt_ready;
   int          func_sel;
   int          ready_mode;
   logic [15:0] rand_tbl;

   int          checks = 0;
   int          errors = 0;
   logic [4:0]  exp_q[$];
   logic [15:0] exp_truth;
   logic [4:0]  exp_n;
   int          sweeps_issued = 0;
   int          done_cnt = 0;

   // DUT-side signals
   logic        busy1, done1, s1, busy3, done3, s3;
   logic [3:0]  abcd1, abcd3;
   logic [15:0] truth1, truth3;
   logic [4:0]  nmax1, nmax3;
   state_t      dbg1, dbg3;

   truth_table_sweeper_if #(.N_VARS(4)) if1 ();
   truth_table_sweeper_if #(.N_VARS(4)) if3 ();
   assign if1.mt_ready = mt_ready;
   assign if3.mt_ready = mt_ready;

   // Reference function under test: 0 PoS list, 1 const 1, 2 const 0, 3 a^d, else random table.
   function automatic logic f_eval(input int fs, input logic [3:0] x, input logic [15:0] tbl);
      case (fs)
         0:       return !(x inside {4'd0, 4'd1, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd14});
         1:       return 1'b1;
         2:       return 1'b0;
         3:       return x[3] ^ x[0];
         default: return tbl[x];
      endcase
   endfunction

   assign s1 = f_eval(func_sel, abcd1, rand_tbl);
   assign s3 = f_eval(func_sel, abcd3, rand_tbl);

   truth_table_sweeper #(.N_VARS(4), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start && !sel), .busy(busy1), .done(done1),
      .abcd(abcd1), .s_in(s1), .truth(truth1), .n_max(nmax1), .mt(if1.master), .dbg_state(dbg1)
   );

   truth_table_sweeper #(.N_VARS(4), .SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start && sel), .busy(busy3), .done(done3),
      .abcd(abcd3), .s_in(s3), .truth(truth3), .n_max(nmax3), .mt(if3.master), .dbg_state(dbg3)
   );

   // Active-instance view
   logic        busy_m, done_m, v_m, last_m;
   logic [3:0]  abcd_m, idx_m;
   logic [15:0] truth_m;
   logic [4:0]  nmax_m;
   int          settle_m;
   assign busy_m   = sel ? busy3 : busy1;
   assign done_m   = sel ? done3 : done1;
   assign v_m      = sel ? if3.mt_valid : if1.mt_valid;
   assign last_m   = sel ? if3.mt_last : if1.mt_last;
   assign idx_m    = sel ? if3.mt_index : if1.mt_index;
   assign abcd_m   = sel ? abcd3 : abcd1;
   assign truth_m  = sel ? truth3 : truth1;
   assign nmax_m   = sel ? nmax3 : nmax1;
   assign settle_m = sel ? 3 : 1;

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Ready driver: 0 always, 1 toggle, 2 held low, 3 random
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       mt_ready = 1'b1;
         1:       mt_ready = !mt_ready;
         2:       mt_ready = 1'b0;
         default: mt_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor
   int         pos = 0;
   int         dl;
   logic       prev_stall = 1'b0;
   logic [4:0] prev_val;
   logic [4:0] e;
   always @(negedge clk) begin
      dl = R * (settle_m + 1);
      if (!rst_n) begin
         check("reset_outputs", {busy_m, done_m, abcd_m, v_m, idx_m, last_m, nmax_m}, 32'd0);
         check("reset_truth", truth_m, 32'd0);
         pos        = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("stall_hold", {v_m, last_m, idx_m}, {1'b1, prev_val});
         if (v_m && mt_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_index", {1'b1, last_m, idx_m}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("mt_index", idx_m, e[3:0]);
               check("mt_last", last_m, e[4]);
            end
         end
         prev_stall = v_m && !mt_ready;
         prev_val   = {last_m, idx_m};
         if (busy_m) begin
            if (pos < dl)       check("abcd_drive", abcd_m, pos / (settle_m + 1));
            else if (pos == dl) check("sweep_length", abcd_m, 32'd0);
         end
         if (done_m) begin
            check("done_count", done_cnt + 1, sweeps_issued);
            check("truth", truth_m, exp_truth);
            check("n_max", nmax_m, exp_n);
            check("stream_drained", exp_q.size(), 32'd0);
            check("busy_at_done", busy_m, 32'd1);
            if (exp_n == 0) check("no_max_latency", pos, dl + 1);
            done_cnt++;
         end
         pos = busy_m ? pos + 1 : 0;
      end
   end

   // Reference model: truth bit i = f(i); maxterms are the zero rows in ascending order.
   task automatic build_model();
      int zeros[$];
      logic b;
      exp_truth = '0;
      for (int i = 0; i < R; i++) begin
         b = f_eval(func_sel, 4'(i), rand_tbl);
         exp_truth[i] = b;
         if (b == 1'b0) zeros.push_back(i);
      end
      exp_n = 5'(zeros.size());
      for (int k = 0; k < zeros.size(); k++) begin
         exp_q.push_back({(k == zeros.size() - 1), 4'(zeros[k])});
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done();
      int cnt = 0;
      while (done_cnt != sweeps_issued) begin
         @(posedge clk);
         cnt++;
         if (cnt > 3000) begin
            $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, sweeps_issued);
            $fatal(1, "timeout");
         end
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic run_sweep(input logic s, input int fs, input int rm);
      sel        = s;
      func_sel   = fs;
      ready_mode = rm;
      rand_tbl   = 16'($urandom);
      build_model();
      sweeps_issued++;
      pulse_start();
      wait_done();
   endtask

   // Driver sequence
   initial begin
      int cnt;
      rst_n = 1'b1; start = 1'b0; sel = 1'b0; func_sel = 0;
      ready_mode = 0; mt_ready = 1'b1; rand_tbl = '0;
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      run_sweep(1'b0, 0, 0);   // PoS(0,1,6,7,8,9,12,14)
      run_sweep(1'b0, 1, 0);   // constant 1
      run_sweep(1'b0, 2, 1);   // constant 0, ready toggling
      run_sweep(1'b1, 3, 0);   // s = a^d on the SETTLE=3 instance

      // Reset in the middle of a sweep, then a full sweep afterwards
      sel = 1'b0; func_sel = 4; ready_mode = 0; rand_tbl = 16'($urandom);
      build_model();
      sweeps_issued++;
      pulse_start();
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
         if (cnt > 200) begin
            $display("FAIL abcd7_timeout: got abcd %0d expected 7", abcd1);
            $fatal(1, "timeout");
         end
      end while (abcd1 != 4'd7);
      rst_n = 1'b0;
      exp_q.delete();
      sweeps_issued--;
      @(posedge clk); #1 rst_n = 1'b1;
      run_sweep(1'b0, 4, 3);

      // start re-asserted while an index is waiting in EMIT
      sel = 1'b0; func_sel = 2; ready_mode = 2;
      build_model();
      sweeps_issued++;
      pulse_start();
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
         if (cnt > 200) begin
            $display("FAIL valid_timeout: got mt_valid %0b expected 1", v_m);
            $fatal(1, "timeout");
         end
      end while (!v_m);
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1 start = 1'b0;
      ready_mode = 3;
      wait_done();

      // Random functions on both instances with random back-pressure
      for (int n = 0; n < 6; n++) begin
         run_sweep(1'($urandom_range(0, 1)), 4, 3);
      end

      repeat (40) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
